// File: rtl/dmem_pkg.sv
// Address map, register-select encoding and STATUS layout for dmem_responder.
package dmem_pkg;

    localparam logic [31:0] IO_BASE = 32'h8000_0000;

    localparam logic [4:0] OFF_TXDATA      = 5'h00;
    localparam logic [4:0] OFF_STATUS      = 5'h04;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h08;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h0C;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h10;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h14;

    typedef enum logic [2:0] {
        REG_TXDATA      = OFF_TXDATA[4:2],
        REG_STATUS      = OFF_STATUS[4:2],
        REG_MTIME_LO    = OFF_MTIME_LO[4:2],
        REG_MTIME_HI    = OFF_MTIME_HI[4:2],
        REG_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2],
        REG_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2],
        REG_RSVD6       = 3'd6,
        REG_RSVD7       = 3'd7
    } io_sel_e;

    localparam int unsigned STATUS_EMPTY    = 0;
    localparam int unsigned STATUS_FULL     = 1;
    localparam int unsigned STATUS_OVERFLOW = 2;

    function automatic io_sel_e io_sel(input logic [31:0] addr);
        return io_sel_e'(addr[4:2]);
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console transmit queue: circular byte buffer with wrap-bit pointers and
// a sticky overflow flag for pushes that arrive while full.
module tx_fifo #(
    parameter int unsigned TXQ_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clr_overflow,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(TXQ_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  buf_q [TXQ_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Fullness is judged before any same-cycle pop, so a push into a full queue is always dropped.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = buf_q[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < TXQ_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                buf_q[wptr[AW-1:0]] <= push_data;
                wptr                <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM below IO_BASE, console queue and optional
// machine timer (enabled by defining DMEM_TIMER_EN) above it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned TXQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_d_we,
    input  logic [31:0] mem_d_wa,
    input  logic [31:0] mem_d_wd,
    output logic [31:0] mem_d_rd,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int unsigned RAM_AW = $clog2(DEPTH);

    logic [31:0]       ram [DEPTH];
    logic [RAM_AW-1:0] ram_idx;
    logic              is_io;
    logic              ram_we;
    logic              io_we;
    io_sel_e           sel;
    logic              q_full;
    logic              q_empty;
    logic              q_overflow;
    logic [31:0]       status_word;
    logic              unused_addr;

    assign ram_idx     = mem_d_wa[RAM_AW+1:2];
    assign is_io       = mem_d_wa[31];
    assign sel         = io_sel(mem_d_wa);
    assign ram_we      = mem_d_we && !is_io;
    assign io_we       = mem_d_we && is_io;
    assign unused_addr = &{1'b0, mem_d_wa[30:RAM_AW+2], mem_d_wa[1:0]};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_d_wd;
        end
    end

    tx_fifo #(
        .TXQ_DEPTH(TXQ_DEPTH)
    ) u_tx_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (io_we && (sel == REG_TXDATA)),
        .push_data    (mem_d_wd[7:0]),
        .pop          (tx_valid && tx_ready),
        .clr_overflow (io_we && (sel == REG_STATUS)),
        .head_data    (tx_data),
        .full         (q_full),
        .empty        (q_empty),
        .overflow     (q_overflow)
    );

    assign tx_valid = !q_empty;

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_EMPTY]    = q_empty;
        status_word[STATUS_FULL]     = q_full;
        status_word[STATUS_OVERFLOW] = q_overflow;
    end

`ifdef DMEM_TIMER_EN
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        irq_q;

    // A write to either mtime half takes the place of that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime    <= '0;
            mtimecmp <= '1;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= (mtime >= mtimecmp);
            if (io_we && (sel == REG_MTIME_LO)) begin
                mtime[31:0] <= mem_d_wd;
            end else if (io_we && (sel == REG_MTIME_HI)) begin
                mtime[63:32] <= mem_d_wd;
            end else begin
                mtime <= mtime + 64'd1;
            end
            if (io_we && (sel == REG_MTIMECMP_LO)) begin
                mtimecmp[31:0] <= mem_d_wd;
            end
            if (io_we && (sel == REG_MTIMECMP_HI)) begin
                mtimecmp[63:32] <= mem_d_wd;
            end
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        mem_d_rd = '0;
        if (!is_io) begin
            mem_d_rd = ram[ram_idx];
        end else begin
            case (sel)
                REG_STATUS:      mem_d_rd = status_word;
`ifdef DMEM_TIMER_EN
                REG_MTIME_LO:    mem_d_rd = mtime[31:0];
                REG_MTIME_HI:    mem_d_rd = mtime[63:32];
                REG_MTIMECMP_LO: mem_d_rd = mtimecmp[31:0];
                REG_MTIMECMP_HI: mem_d_rd = mtimecmp[63:32];
`endif
                default:         mem_d_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus random bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned TXQ   = 8;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_MT_LO  = 32'h8000_0008;
    localparam logic [31:0] A_MT_HI  = 32'h8000_000C;
    localparam logic [31:0] A_CMP_LO = 32'h8000_0010;
    localparam logic [31:0] A_CMP_HI = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_d_we = 1'b0;
    logic [31:0] mem_d_wa = '0;
    logic [31:0] mem_d_wd = '0;
    logic [31:0] mem_d_rd;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    int checks = 0;
    int passes = 0;

    logic [31:0] ram_m [int unsigned];
    logic [7:0]  q[$];
    bit          ovf_m;
    logic [63:0] mtime_m;
    logic [63:0] cmp_m;
    bit          irq_m;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH     (DEPTH),
        .TXQ_DEPTH (TXQ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_d_we  (mem_d_we),
        .mem_d_wa  (mem_d_wa),
        .mem_d_wd  (mem_d_wd),
        .mem_d_rd  (mem_d_rd),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m   = 1'b0;
        mtime_m = '0;
        cmp_m   = '1;
        irq_m   = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a, output bit known);
        int unsigned idx = (a >> 2) % DEPTH;
        int unsigned sel = (a >> 2) % 8;
        known = 1'b1;
        if (a < 32'h8000_0000) begin
            if (ram_m.exists(idx)) return ram_m[idx];
            known = 1'b0;
            return '0;
        end
        case (sel)
            1: return {29'd0, ovf_m, q.size() == TXQ, q.size() == 0};
            2: return TIMER ? mtime_m[31:0]  : 32'd0;
            3: return TIMER ? mtime_m[63:32] : 32'd0;
            4: return TIMER ? cmp_m[31:0]    : 32'd0;
            5: return TIMER ? cmp_m[63:32]   : 32'd0;
            default: return '0;
        endcase
    endfunction

    task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d, input bit ready);
        int unsigned sel     = (a >> 2) % 8;
        bit          io      = (a >= 32'h8000_0000);
        bit          was_full = (q.size() == TXQ);
        bit          pop     = (q.size() != 0) && ready;
        logic [63:0] t_next  = mtime_m + 64'd1;
        irq_m = TIMER && (mtime_m >= cmp_m);
        if (we && !io) ram_m[(a >> 2) % DEPTH] = d;
        if (pop) void'(q.pop_front());
        if (we && io) begin
            case (sel)
                0: if (was_full) ovf_m = 1'b1; else q.push_back(d[7:0]);
                1: ovf_m = 1'b0;
                2: t_next = {mtime_m[63:32], d};
                3: t_next = {d, mtime_m[31:0]};
                4: cmp_m[31:0]  = d;
                5: cmp_m[63:32] = d;
                default: ;
            endcase
        end
        mtime_m = t_next;
    endtask

    // One clock: drive at posedge+1, check the combinational read, then the registered outputs.
    task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d, input bit ready);
        logic [31:0] exp_rd;
        bit          known;
        mem_d_we = we;
        mem_d_wa = a;
        mem_d_wd = d;
        tx_ready = ready;
        #1;
        exp_rd = model_rd(a, known);
        if (known) chk($sformatf("rd@%h", a), mem_d_rd, exp_rd);
        @(posedge clk);
        model_edge(we, a, d, ready);
        #1;
        chk("tx_valid", tx_valid, q.size() != 0);
        if (q.size() != 0) chk("tx_data", tx_data, q[0]);
        chk("timer_irq", timer_irq, irq_m);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_d_we = 1'b0;
        mem_d_wa = a;
        #1;
        chk(tag, mem_d_rd, exp);
    endtask

    initial begin
        bit          seen;
        logic [31:0] a;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_irq", timer_irq, 0);
        peek("rst_status", A_STATUS, 32'h1);
        reset = 1'b1;

        // timer compare
        cycle(1'b1, A_CMP_HI, 32'd0, 1'b0);
        cycle(1'b1, A_CMP_LO, 32'd20, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, A_MT_LO, 32'd0, 1'b0);
            if (timer_irq && !seen) begin
                seen = 1'b1;
                chk("irq_rise_mtime", mem_d_rd, 32'd21);
            end
        end
`ifdef DMEM_TIMER_EN
        chk("irq_seen", seen, 1'b1);
`else
        chk("irq_tied_low", timer_irq, 1'b0);
        peek("mtime_absent", A_MT_LO, 32'd0);
`endif

        // RAM write/read, alias of byte offset, same-cycle old value
        cycle(1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
        mem_d_we = 1'b1; mem_d_wa = 32'h0000_0010; mem_d_wd = 32'hDEAD_BEEF;
        #1;
        chk("same_cycle_old", mem_d_rd, 32'h1111_1111);
        @(posedge clk);
        model_edge(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        #1;
        peek("ram_rd_10", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("ram_rd_13", 32'h0000_0013, 32'hDEAD_BEEF);

        // fill, overflow, clear, drain
        for (int i = 0; i < 9; i++) cycle(1'b1, A_TX, 32'h41 + i, 1'b0);
        peek("status_full_ovf", A_STATUS, 32'h6);
        cycle(1'b1, A_STATUS, 32'd0, 1'b0);
        peek("status_ovf_clr", A_STATUS, 32'h2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_byte", tx_data, 8'h41 + i);
            cycle(1'b0, A_STATUS, 32'd0, 1'b1);
        end
        chk("drained", tx_valid, 1'b0);

        // steady push+pop with 3 entries held
        for (int i = 0; i < 3; i++) cycle(1'b1, A_TX, 32'h50 + i, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stream_order", tx_data, 8'h50 + i);
            cycle(1'b1, A_TX, 32'h53 + i, 1'b1);
        end
        peek("stream_status", A_STATUS, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, A_STATUS, 32'd0, 1'b1);

        // mtime wrap
        cycle(1'b1, A_MT_LO, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, A_MT_HI, 32'hFFFF_FFFF, 1'b0);
`ifdef DMEM_TIMER_EN
        peek("mtime_max_hi", A_MT_HI, 32'hFFFF_FFFF);
`endif
        cycle(1'b0, A_MT_LO, 32'd0, 1'b0);
        peek("mtime_wrap_lo", A_MT_LO, 32'd0);
        peek("mtime_wrap_hi", A_MT_HI, 32'd0);

        // asynchronous reset with bytes queued
        for (int i = 0; i < 4; i++) cycle(1'b1, A_TX, 32'h60 + i, 1'b0);
        chk("queued_before_reset", tx_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("reset_async_valid", tx_valid, 1'b0);
        chk("reset_async_data", tx_data, 8'h00);
        model_reset();
        reset = 1'b1;
        peek("after_reset_mtime", A_MT_LO, 32'd0);
        peek("after_reset_status", A_STATUS, 32'h1);
        peek("after_reset_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        cycle(1'b0, A_MT_LO, 32'd0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                a = ($urandom & 32'h7FFF_F003) | (32'($urandom_range(0, 15)) << 2);
            end else begin
                a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
            end
            cycle($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the five-stage RISC-V core. It answers the core's data port (`mem_d_*`) with a word RAM plus a small memory-mapped I/O window: a console transmit queue with a valid/ready drain interface and a 64-bit machine timer with compare interrupt. Reads are combinational so the core's memory stage sees data in the same cycle. All writes commit on the clock edge.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `TXQ_DEPTH`, 8: console queue entries; power of two, ≥2.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `mem_d_we` in 1: write strobe from core.
- `mem_d_wa` in 32: byte address for both read and write.
- `mem_d_wd` in 32: write data.
- `mem_d_rd` out 32: read data, combinational from `mem_d_wa`.
- `tx_valid` out 1: queue head valid.
- `tx_data` out 8: queue head byte.
- `tx_ready` in 1: consumer accepts head when high with `tx_valid`.
- `timer_irq` out 1: registered, high while `mtime >= mtimecmp`.

## Operation
- Decode on `mem_d_wa[31]`.
  - 0: RAM, word index `mem_d_wa[log2(DEPTH)+1:2]`.
  - 1: I/O, register select `mem_d_wa[4:2]`.
  - Byte offset `[1:0]` is ignored. Upper RAM address bits alias.
- Full-word accesses only; no byte enables.
- RAM contents are not reset.
- I/O map (offset from `0x8000_0000`):
  - `0x00` TXDATA: write pushes `wd[7:0]`; read returns 0.
  - `0x04` STATUS: read `{29'b0, overflow, full, empty}`; any write clears `overflow`.
  - `0x08` MTIME_LO and `0x0C` MTIME_HI: R/W.
  - `0x10` MTIMECMP_LO and `0x14` MTIMECMP_HI: R/W.
  - `0x18` and `0x1C`: read 0, writes ignored.
- TX queue:
  - Circular buffer with read/write pointers one bit wider than `log2(TXQ_DEPTH)`.
  - `full` = MSBs differ and rest equal. `empty` = pointers equal.
  - Push while full: byte dropped, `overflow` set sticky. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full or empty: both occur, count unchanged.
  - Pop happens when `tx_valid && tx_ready`.
  - `tx_valid` = !empty. `tx_data` = entry at read pointer.
- Timer:
  - `mtime` increments by 1 every cycle and wraps `2^64-1 → 0`.
  - A write to either half replaces that half and suppresses the increment for that cycle; the other half holds.
  - `mtimecmp` is only changed by writes.
  - `timer_irq` <= (`mtime >= mtimecmp`), a 64-bit unsigned compare on current register values.

## Timing
- Read latency 0: `mem_d_rd` follows `mem_d_wa` combinationally. A read in the same cycle as a write to the same location returns the old value.
- Write visible to reads the cycle after the edge.
- Push to an empty queue: `tx_valid` rises the cycle after the write edge. There is no fall-through.
- `timer_irq` lags the compare by one cycle.
- Reset values:
  - Queue empty: `tx_valid`=0, `tx_data`=0, `overflow`=0.
  - `mtime`=0, `mtimecmp`=all ones, `timer_irq`=0.
- Reset asserted mid-operation discards queued bytes immediately and asynchronously; RAM is untouched.

## Configuration
- `DMEM_TIMER_EN` defined: timer registers and `timer_irq` are present as above.
- Not defined:
  - Offsets `0x08–0x14` read 0, writes ignored.
  - `timer_irq` tied to 0.
  - No timer flops are instantiated.

## Structure
- `dmem_pkg` holds:
  - `IO_BASE` = `32'h8000_0000`.
  - Register offset localparams (`OFF_TXDATA` … `OFF_MTIMECMP_HI`).
  - `typedef enum logic [2:0]` for the register select.
  - The STATUS bit positions.
- One sub-module, `tx_fifo`: parameterised by `TXQ_DEPTH`, with push/pop/full/empty/overflow and async active-low reset.
- RAM is an inferred array inside `dmem_responder`.

## Test plan
- Write `0xDEADBEEF` to `0x0000_0010`, then read `0x0000_0010` and `0x0000_0013` → both return `0xDEADBEEF`; same-cycle read still shows the old value.
- Push 8 bytes `0x41..0x48` with `tx_ready`=0, then push `0x49` → STATUS = `0x6`. Write STATUS → `0x2`. Raise `tx_ready` → bytes `0x41..0x48` drain one per cycle, then `tx_valid`=0.
- Queue holding 3 entries with `tx_ready`=1 while pushing each cycle → count stays 3 and output order is preserved.
- Write `MTIMECMP_HI`=0 and `MTIMECMP_LO`=20 after reset → `timer_irq` rises on the cycle after `mtime` reaches 20.
- Write `MTIME_LO`=`0xFFFF_FFFF` and `MTIME_HI`=`0xFFFF_FFFF` → two cycles later `mtime` reads 0 (wrapped).
- Assert `reset` with 4 bytes queued → `tx_valid` drops immediately; after release STATUS = `0x1`; `mtime` restarts at 0.
